// File: rtl/tcp_pkg.sv
// tcp_pkg: shared TCP types, constants and scheduler command encodings
package tcp_pkg;
  localparam int FLOWID_W = 8;
  localparam int IP_ADDR_W = 32;
  localparam int PORT_W = 16;
  localparam int TX_PAYLOAD_PTR_W = 14;
  localparam int TIMESTAMP_W = 16;
  localparam int MSS_DEFAULT = 1024;
  localparam logic [3:0] TCP_HDR_WORDS = 4'd5;
  localparam logic [7:0] TCP_ACK = 8'h10;
  localparam logic [7:0] TCP_PSH = 8'h08;
  typedef enum logic [1:0] {SCHED_NOP = 2'd0, SCHED_SET = 2'd1, SCHED_CLEAR = 2'd2} sched_op_e;
  typedef enum logic [2:0] {IDLE, RD, CALC, SEND, WB} seg_state_e;
  typedef struct packed {
    logic [31:0] ack_num;
  } ack_state_struct;
  typedef struct packed {
    logic [31:0] our_seq_num;
    ack_state_struct our_ack_state;
    logic [15:0] their_win_size;
  } smol_tx_state_struct;
  typedef struct packed {
    logic [31:0] their_ack_num;
    logic [15:0] our_win_size;
  } smol_rx_state_struct;
  typedef struct packed {
    logic [IP_ADDR_W-1:0] host_ip;
    logic [IP_ADDR_W-1:0] dest_ip;
    logic [PORT_W-1:0] host_port;
    logic [PORT_W-1:0] dest_port;
  } four_tuple_struct;
  typedef struct packed {
    logic [PORT_W-1:0] src_port;
    logic [PORT_W-1:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [3:0] data_offset;
    logic [3:0] reserved;
    logic [7:0] flags;
    logic [15:0] win_size;
    logic [15:0] chksum;
    logic [15:0] urg_pointer;
  } tcp_pkt_hdr;
  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    sched_op_e rt_pend;
    sched_op_e ack_pend;
    sched_op_e data_pend;
    logic [TIMESTAMP_W-1:0] rt_pend_timestamp;
    logic [TIMESTAMP_W-1:0] data_pend_timestamp;
  } sched_cmd_struct;
endpackage

// File: rtl/tcp_hdr_assembler.sv
// tcp_hdr_assembler: packs TCP header fields; checksum is filled downstream
module tcp_hdr_assembler import tcp_pkg::*; (
  input  logic [PORT_W-1:0] src_port,
  input  logic [PORT_W-1:0] dst_port,
  input  logic [31:0]       seq_num,
  input  logic [31:0]       ack_num,
  input  logic [7:0]        flags,
  input  logic [15:0]       win_size,
  output tcp_pkt_hdr        hdr
);
  always_comb begin
    hdr = '0;
    hdr.src_port = src_port;
    hdr.dst_port = dst_port;
    hdr.seq_num = seq_num;
    hdr.ack_num = ack_num;
    hdr.data_offset = TCP_HDR_WORDS;
    hdr.flags = flags;
    hdr.win_size = win_size;
  end
endmodule

// File: rtl/tcp_tx_len_calc.sv
// tcp_tx_len_calc: picks segment length and start sequence for new or retransmitted data
module tcp_tx_len_calc import tcp_pkg::*; #(
  parameter int MSS_BYTES = MSS_DEFAULT
) (
  input  logic                      rt,
  input  smol_tx_state_struct       tx_state,
  input  logic [TX_PAYLOAD_PTR_W:0] tail_ptr,
  output logic [15:0]               len,
  output logic [31:0]               seq,
  output logic [TX_PAYLOAD_PTR_W:0] unsent
);
  logic [31:0] inflight, win, win_avail, lim_a, lim_b, pick;
  assign inflight = tx_state.our_seq_num - tx_state.our_ack_state.ack_num;
  assign unsent = tail_ptr - tx_state.our_seq_num[TX_PAYLOAD_PTR_W:0];
  assign win = 32'(tx_state.their_win_size);
  assign win_avail = win > inflight ? win - inflight : '0;
  assign lim_a = rt ? inflight : 32'(unsent);
  assign lim_b = rt ? win : win_avail;
  assign pick = lim_a < lim_b ? lim_a : lim_b;
  assign len = 16'(pick < 32'(MSS_BYTES) ? pick : 32'(MSS_BYTES));
  assign seq = rt ? tx_state.our_ack_state.ack_num : tx_state.our_seq_num;
endmodule

// File: rtl/tcp_tx_seg_gen.sv
// tcp_tx_seg_gen: reads flow state, sizes one TX segment, emits it and writes state back
module tcp_tx_seg_gen import tcp_pkg::*; #(
  parameter int MSS_BYTES = MSS_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sched_req_val,
  output logic                        sched_req_rdy,
  input  logic [FLOWID_W-1:0]         sched_req_flowid,
  input  logic                        sched_req_rt,
  output logic [FLOWID_W-1:0]         state_rd_req_addr,
  input  smol_tx_state_struct         tx_state_rd_resp_data,
  input  smol_rx_state_struct         rx_state_rd_resp_data,
  input  logic [TX_PAYLOAD_PTR_W:0]   tx_tail_ptr_rd_resp_data,
  input  four_tuple_struct            flow_lookup_rd_resp_data,
  output logic                        tx_state_wr_req_val,
  output logic [FLOWID_W-1:0]         tx_state_wr_req_addr,
  output smol_tx_state_struct         tx_state_wr_req_data,
  output logic                        tx_seg_val,
  input  logic                        tx_seg_rdy,
  output tcp_pkt_hdr                  tx_seg_hdr,
  output logic [FLOWID_W-1:0]         tx_seg_flowid,
  output logic [IP_ADDR_W-1:0]        tx_seg_src_ip,
  output logic [IP_ADDR_W-1:0]        tx_seg_dst_ip,
  output logic [TX_PAYLOAD_PTR_W-1:0] tx_seg_payload_addr,
  output logic [15:0]                 tx_seg_payload_len,
  output logic                        tx_sched_update_val,
  output sched_cmd_struct             tx_sched_update_cmd
);
  seg_state_e state, next;
  logic [FLOWID_W-1:0] flowid_r;
  logic rt_r;
  smol_tx_state_struct tx_st;
  smol_rx_state_struct rx_st;
  logic [TX_PAYLOAD_PTR_W:0] tail_r, unsent_c, unsent_r;
  four_tuple_struct tuple_r;
  logic [15:0] len_c, len_r;
  logic [31:0] seq_c, seq_r;
  tcp_tx_len_calc #(.MSS_BYTES(MSS_BYTES)) u_len (
    .rt(rt_r), .tx_state(tx_st), .tail_ptr(tail_r),
    .len(len_c), .seq(seq_c), .unsent(unsent_c)
  );
  tcp_hdr_assembler u_hdr (
    .src_port(tuple_r.host_port), .dst_port(tuple_r.dest_port),
    .seq_num(seq_r), .ack_num(rx_st.their_ack_num),
    .flags(len_r != '0 ? (TCP_ACK | TCP_PSH) : TCP_ACK),
    .win_size(rx_st.our_win_size), .hdr(tx_seg_hdr)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      flowid_r <= '0;
      rt_r <= 1'b0;
      tx_st <= '0;
      rx_st <= '0;
      tail_r <= '0;
      tuple_r <= '0;
      len_r <= '0;
      seq_r <= '0;
      unsent_r <= '0;
    end else begin
      state <= next;
      if (state == IDLE && sched_req_val) begin
        flowid_r <= sched_req_flowid;
        rt_r <= sched_req_rt;
      end
      if (state == RD) begin
        tx_st <= tx_state_rd_resp_data;
        rx_st <= rx_state_rd_resp_data;
        tail_r <= tx_tail_ptr_rd_resp_data;
        tuple_r <= flow_lookup_rd_resp_data;
      end
      if (state == CALC) begin
        len_r <= len_c;
        seq_r <= seq_c;
        unsent_r <= unsent_c;
      end
    end
  end
  always_comb begin
    next = state;
    unique case (state)
      IDLE: next = sched_req_val ? RD : IDLE;
      RD: next = CALC;
      CALC: next = SEND;
      SEND: next = tx_seg_rdy ? WB : SEND;
      WB: next = IDLE;
      default: next = IDLE;
    endcase
  end
  // write-back only advances the send pointer for new data; retransmits leave state untouched
  always_comb begin
    tx_state_wr_req_data = tx_st;
    tx_state_wr_req_data.our_seq_num = rt_r ? tx_st.our_seq_num : tx_st.our_seq_num + 32'(len_r);
    tx_sched_update_cmd = '0;
    tx_sched_update_cmd.flowid = flowid_r;
    tx_sched_update_cmd.ack_pend = SCHED_CLEAR;
    tx_sched_update_cmd.rt_pend = rt_r ? SCHED_CLEAR : SCHED_NOP;
    tx_sched_update_cmd.data_pend = (!rt_r && 16'(unsent_r) > len_r) ? SCHED_SET : SCHED_CLEAR;
  end
  assign sched_req_rdy = state == IDLE && !rst;
  assign state_rd_req_addr = flowid_r;
  assign tx_state_wr_req_val = state == WB;
  assign tx_state_wr_req_addr = flowid_r;
  assign tx_sched_update_val = state == WB;
  assign tx_seg_val = state == SEND;
  assign tx_seg_flowid = flowid_r;
  assign tx_seg_src_ip = tuple_r.host_ip;
  assign tx_seg_dst_ip = tuple_r.dest_ip;
  assign tx_seg_payload_addr = seq_r[TX_PAYLOAD_PTR_W-1:0];
  assign tx_seg_payload_len = len_r;
endmodule

// File: tb/tb_tcp_tx_seg_gen.sv
// tb_tcp_tx_seg_gen: scoreboard bench for the TCP TX segment generator
module tb_tcp_tx_seg_gen;
  import tcp_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic sched_req_val = 1'b0, sched_req_rdy, sched_req_rt = 1'b0;
  logic [FLOWID_W-1:0] sched_req_flowid = '0, state_rd_req_addr, tx_state_wr_req_addr, tx_seg_flowid;
  smol_tx_state_struct tx_state_rd_resp_data = '0, tx_state_wr_req_data;
  smol_rx_state_struct rx_state_rd_resp_data = '0;
  logic [TX_PAYLOAD_PTR_W:0] tx_tail_ptr_rd_resp_data = '0;
  four_tuple_struct flow_lookup_rd_resp_data;
  logic tx_state_wr_req_val, tx_seg_val, tx_seg_rdy = 1'b1, tx_sched_update_val;
  tcp_pkt_hdr tx_seg_hdr;
  logic [IP_ADDR_W-1:0] tx_seg_src_ip, tx_seg_dst_ip;
  logic [TX_PAYLOAD_PTR_W-1:0] tx_seg_payload_addr;
  logic [15:0] tx_seg_payload_len;
  sched_cmd_struct tx_sched_update_cmd;
  assign flow_lookup_rd_resp_data = '{host_ip: 32'h0A000001, dest_ip: 32'h0A000002, host_port: 16'h1234, dest_port: 16'h5678};
  tcp_tx_seg_gen dut (
    .clk(clk), .rst(rst),
    .sched_req_val(sched_req_val), .sched_req_rdy(sched_req_rdy),
    .sched_req_flowid(sched_req_flowid), .sched_req_rt(sched_req_rt),
    .state_rd_req_addr(state_rd_req_addr),
    .tx_state_rd_resp_data(tx_state_rd_resp_data), .rx_state_rd_resp_data(rx_state_rd_resp_data),
    .tx_tail_ptr_rd_resp_data(tx_tail_ptr_rd_resp_data), .flow_lookup_rd_resp_data(flow_lookup_rd_resp_data),
    .tx_state_wr_req_val(tx_state_wr_req_val), .tx_state_wr_req_addr(tx_state_wr_req_addr),
    .tx_state_wr_req_data(tx_state_wr_req_data),
    .tx_seg_val(tx_seg_val), .tx_seg_rdy(tx_seg_rdy), .tx_seg_hdr(tx_seg_hdr),
    .tx_seg_flowid(tx_seg_flowid), .tx_seg_src_ip(tx_seg_src_ip), .tx_seg_dst_ip(tx_seg_dst_ip),
    .tx_seg_payload_addr(tx_seg_payload_addr), .tx_seg_payload_len(tx_seg_payload_len),
    .tx_sched_update_val(tx_sched_update_val), .tx_sched_update_cmd(tx_sched_update_cmd)
  );
  typedef struct {
    logic [7:0] fid;
    logic [31:0] seq;
    logic [15:0] len;
    logic [7:0] flags;
    logic [13:0] addr;
    logic [31:0] wb_seq;
    logic [1:0] rt_pend;
    logic [1:0] data_pend;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int vectors = 0, errs = 0, wb_cnt = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && tx_seg_val && tx_seg_rdy) begin
      chk("seg_queue", 64'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q[0];
        chk("seg_flowid", tx_seg_flowid, e.fid);
        chk("seg_seq", tx_seg_hdr.seq_num, e.seq);
        chk("seg_len", tx_seg_payload_len, e.len);
        chk("seg_flags", tx_seg_hdr.flags, e.flags);
        chk("seg_addr", tx_seg_payload_addr, e.addr);
        chk("seg_ack", tx_seg_hdr.ack_num, 32'hDEAD0000 | 32'(e.fid));
        chk("seg_win", tx_seg_hdr.win_size, 16'h2000);
        chk("seg_ports", {tx_seg_hdr.src_port, tx_seg_hdr.dst_port}, 32'h12345678);
        chk("seg_ips", {tx_seg_src_ip, tx_seg_dst_ip}, 64'h0A000001_0A000002);
      end
    end
    if (!rst && tx_state_wr_req_val) begin
      wb_cnt++;
      chk("wb_queue", 64'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wb_addr", tx_state_wr_req_addr, e.fid);
        chk("wb_seq", tx_state_wr_req_data.our_seq_num, e.wb_seq);
        chk("upd_val", tx_sched_update_val, 1);
        chk("upd_flowid", tx_sched_update_cmd.flowid, e.fid);
        chk("upd_ack_pend", tx_sched_update_cmd.ack_pend, SCHED_CLEAR);
        chk("upd_rt_pend", tx_sched_update_cmd.rt_pend, e.rt_pend);
        chk("upd_data_pend", tx_sched_update_cmd.data_pend, e.data_pend);
        chk("upd_ts", {tx_sched_update_cmd.rt_pend_timestamp, tx_sched_update_cmd.data_pend_timestamp}, 0);
      end
    end
  end
  task automatic run(input logic [7:0] fid, input logic rt, input logic [31:0] seq, input logic [31:0] ack,
                     input logic [15:0] win, input logic [14:0] tail, input exp_t x, input bit push);
    tx_state_rd_resp_data = '{our_seq_num: seq, our_ack_state: '{ack_num: ack}, their_win_size: win};
    rx_state_rd_resp_data = '{their_ack_num: 32'hDEAD0000 | 32'(fid), our_win_size: 16'h2000};
    tx_tail_ptr_rd_resp_data = tail;
    if (push) q.push_back(x);
    sched_req_flowid = fid;
    sched_req_rt = rt;
    sched_req_val = 1'b1;
    @(posedge clk);
    #1 sched_req_val = 1'b0;
  endtask
  task automatic wait_wb(input int prev);
    int n = 0;
    while (wb_cnt == prev && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("wb_seen", 64'(wb_cnt != prev), 1);
    #1;
  endtask
  task automatic wait_send();
    int n = 0;
    while (!tx_seg_val && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_reached", tx_seg_val, 1);
  endtask
  initial begin
    int prev;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", sched_req_rdy, 0);
    chk("rst_vals", {tx_seg_val, tx_state_wr_req_val, tx_sched_update_val}, 0);
    chk("rst_addr", state_rd_req_addr, 0);
    chk("rst_hdr_seq", tx_seg_hdr.seq_num, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", sched_req_rdy, 1);
    @(posedge clk);
    #1;
    prev = wb_cnt;
    run(8'h05, 0, 32'h100, 32'h100, 16'h1000, 15'h180,
        '{fid: 8'h05, seq: 32'h100, len: 16'h80, flags: 8'h18, addr: 14'h100, wb_seq: 32'h180, rt_pend: 2'd0, data_pend: 2'd2}, 1);
    wait_wb(prev);
    prev = wb_cnt;
    run(8'h11, 0, 32'h1000, 32'h1000, 16'hFFFF, 15'h1BB8,
        '{fid: 8'h11, seq: 32'h1000, len: 16'h400, flags: 8'h18, addr: 14'h1000, wb_seq: 32'h1400, rt_pend: 2'd0, data_pend: 2'd1}, 1);
    wait_wb(prev);
    prev = wb_cnt;
    run(8'h22, 0, 32'h400, 32'h200, 16'h200, 15'h450,
        '{fid: 8'h22, seq: 32'h400, len: 16'h0, flags: 8'h10, addr: 14'h400, wb_seq: 32'h400, rt_pend: 2'd0, data_pend: 2'd1}, 1);
    wait_wb(prev);
    prev = wb_cnt;
    run(8'h33, 1, 32'h300, 32'h100, 16'h1000, 15'h300,
        '{fid: 8'h33, seq: 32'h100, len: 16'h200, flags: 8'h18, addr: 14'h100, wb_seq: 32'h300, rt_pend: 2'd2, data_pend: 2'd2}, 1);
    wait_wb(prev);
    // backpressure across the buffer wrap point; a competing request must be ignored
    prev = wb_cnt;
    tx_seg_rdy = 1'b0;
    run(8'h03, 0, 32'h7FF0, 32'h7FF0, 16'h1000, 15'h0010,
        '{fid: 8'h03, seq: 32'h7FF0, len: 16'h20, flags: 8'h18, addr: 14'h3FF0, wb_seq: 32'h8010, rt_pend: 2'd0, data_pend: 2'd2}, 1);
    wait_send();
    sched_req_flowid = 8'h09;
    sched_req_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_val", tx_seg_val, 1);
      chk("bp_rdy", sched_req_rdy, 0);
      chk("bp_addr", tx_seg_payload_addr, 14'h3FF0);
      chk("bp_len", tx_seg_payload_len, 16'h20);
      chk("bp_seq", tx_seg_hdr.seq_num, 32'h7FF0);
    end
    sched_req_val = 1'b0;
    chk("bp_rd_addr", state_rd_req_addr, 8'h03);
    @(posedge clk);
    #1 tx_seg_rdy = 1'b1;
    wait_wb(prev);
    prev = wb_cnt;
    run(8'h04, 0, 32'h1C000, 32'h1C000, 16'h1000, 15'h4040,
        '{fid: 8'h04, seq: 32'h1C000, len: 16'h40, flags: 8'h18, addr: 14'h0, wb_seq: 32'h1C040, rt_pend: 2'd0, data_pend: 2'd2}, 1);
    wait_wb(prev);
    prev = wb_cnt;
    tx_seg_rdy = 1'b0;
    run(8'h07, 0, 32'h100, 32'h100, 16'h1000, 15'h180, e, 0);
    wait_send();
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("async_rst_val", tx_seg_val, 0);
    @(negedge clk);
    chk("mid_rst_rdy", sched_req_rdy, 0);
    chk("mid_rst_vals", {tx_seg_val, tx_state_wr_req_val, tx_sched_update_val}, 0);
    chk("mid_rst_addr", state_rd_req_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tx_seg_rdy = 1'b1;
    @(negedge clk);
    chk("rdy_after_abort", sched_req_rdy, 1);
    repeat (8) @(negedge clk);
    chk("no_wb_after_abort", wb_cnt, prev);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end
endmodule

// File: doc/tcp_tx_seg_gen.md
TCP_TX_SEG_GEN -- requirements
Module: tcp_tx_seg_gen

Interface
REQ-001 SHALL have parameter MSS_BYTES, default 1024, the maximum payload bytes per emitted segment.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk (input, 1) and rst (input, 1).
REQ-003 sched_req_val  in  1  scheduler requests service for one flow.
REQ-004 sched_req_rdy  out  1  block accepts a request (high only in IDLE).
REQ-005 sched_req_flowid  in  FLOWID_W  flow to service.
REQ-006 sched_req_rt  in  1  request is a retransmit.
REQ-007 state_rd_req_addr  out  FLOWID_W  shared read address for the tx-state, rx-state, tx-tail-ptr and flow-lookup memories.
REQ-008 tx_state_rd_resp_data  in  smol_tx_state_struct  current tx state.
REQ-009 rx_state_rd_resp_data  in  smol_rx_state_struct  current rx state.
REQ-010 tx_tail_ptr_rd_resp_data  in  TX_PAYLOAD_PTR_W+1  application write pointer.
REQ-011 flow_lookup_rd_resp_data  in  four_tuple_struct  flow addresses and ports.
REQ-012 tx_state_wr_req_val / addr / data  out  1 / FLOWID_W / smol_tx_state_struct  tx-state write-back.
REQ-013 tx_seg_val / tx_seg_rdy  out / in  1 / 1  segment handshake.
REQ-014 tx_seg_hdr  out  tcp_pkt_hdr  assembled TCP header.
REQ-015 tx_seg_flowid, tx_seg_src_ip, tx_seg_dst_ip  out  FLOWID_W, IP_ADDR_W, IP_ADDR_W  segment metadata.
REQ-016 tx_seg_payload_addr / tx_seg_payload_len  out  TX_PAYLOAD_PTR_W / 16  payload buffer descriptor.
REQ-017 tx_sched_update_val / tx_sched_update_cmd  out  1 / sched_cmd_struct  pending-bit update.

Function
REQ-018 The FSM SHALL have states IDLE, RD, CALC, SEND and WB, with transitions IDLE->RD on val&rdy, RD->CALC after exactly one cycle (memory latency 1), CALC->SEND, SEND->WB on tx_seg_rdy, and WB->IDLE.
REQ-019 In IDLE the block SHALL latch the flowid and rt bit, and state_rd_req_addr SHALL reflect the latched flowid from RD onward.
REQ-020 In RD the block SHALL register all four read responses.
REQ-021 inflight SHALL equal our_seq_num - our_ack_state.ack_num, computed in 32-bit modular arithmetic.
REQ-022 unsent SHALL equal tail_ptr - our_seq_num[TX_PAYLOAD_PTR_W:0], computed modulo 2^(TX_PAYLOAD_PTR_W+1).
REQ-023 win_avail SHALL equal their_win_size - inflight when their_win_size > inflight, and 0 otherwise.
REQ-024 For a normal request, len = min(unsent, win_avail, MSS_BYTES) and seq = our_seq_num.
REQ-025 For a retransmit request, len = min(inflight, their_win_size, MSS_BYTES) and seq = our_ack_state.ack_num.
REQ-026 Header fields: src_port = host_port, dst_port = dest_port, seq_num = seq, ack_num = their_ack_num, win_size = our_win_size.
REQ-027 Header flags SHALL be ACK, plus PSH when len > 0; src_ip = host_ip and dst_ip = dest_ip.
REQ-028 tx_seg_payload_addr SHALL equal seq[TX_PAYLOAD_PTR_W-1:0], so wrap-around is implicit in the truncation.
REQ-029 A len == 0 result SHALL still emit a pure ACK.
REQ-030 In SEND, tx_seg_val SHALL hold with all tx_seg_* outputs stable until tx_seg_rdy is high.
REQ-031 In WB, tx_state_wr_req_val SHALL pulse for one cycle with our_seq_num + len for normal requests, or the unchanged state for retransmits.
REQ-032 In WB, tx_sched_update_val SHALL pulse for one cycle with the following command content:
  - ack_pend = CLEAR;
  - rt_pend = CLEAR if rt, otherwise NOP;
  - data_pend = SET if normal and unsent > len, otherwise CLEAR;
  - all timestamps 0.
REQ-033 Single-cycle strobes SHALL be low outside their states, and sched_req_val SHALL be ignored outside IDLE.

Reset
REQ-034 Reset SHALL place the FSM in IDLE asynchronously, and while in reset all val outputs and sched_req_rdy SHALL be 0 and datapath registers SHALL be 0.
REQ-035 Reset asserted mid-operation (any state, including SEND with val high) SHALL abort the operation with no write-back and no sched update.
REQ-036 sched_req_rdy SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-037 MSS default, the flag constants and the sched command encodings SHALL reside in tcp_pkg.
REQ-038 The struct types SHALL be reused from their existing packages.
REQ-039 Length selection (REQ-021..REQ-025) SHALL be one combinational sub-module, tcp_tx_len_calc.
REQ-040 Header assembly SHALL reuse tcp_hdr_assembler.

Verification
REQ-041 Normal segment: seq=0x100, ack=0x100, tail=0x180, win=0x1000 -> len=0x80, seq=0x100, PSH|ACK, write-back seq=0x180, data_pend CLEAR.
REQ-042 MSS clamp: unsent=3000, win=0xFFFF -> len=1024, write-back seq+1024, data_pend SET.
REQ-043 Window closed: inflight=0x200, their_win=0x200, unsent=0x50 -> len=0, pure ACK, seq unchanged.
REQ-044 Retransmit: ack=0x100, seq=0x300, win=0x1000 -> seq_num=0x100, len=0x200, tx state unchanged, rt_pend CLEAR.
REQ-045 Backpressure plus wrap: tx_seg_rdy low for 5 cycles with seq near 2^TX_PAYLOAD_PTR_W -> outputs stable, payload_addr wraps to 0 correctly.
REQ-046 Reset during SEND -> no write-back strobe, IDLE, and rdy=1 after release.
